// File: rtl/tick_scheduler.sv
// Tick scheduler: issues a pulse every `period` cycles for `count` ticks (0 = until stopped),
// handing each tick round-robin to the next enabled consumer channel.
module tick_scheduler #(
  parameter int          NUM_CH     = 4,
  parameter logic [19:0] DEF_PERIOD = 20'd16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [19:0]       cfg_period,
  input  logic [15:0]       cfg_count,
  input  logic [NUM_CH-1:0] cfg_mask,
  input  logic              start,
  input  logic              stop,
  output logic              tick,
  output logic [NUM_CH-1:0] tick_vec,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [19:0]       period_q, period_d;
  logic [15:0]       count_q, count_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [19:0]       cyc_q, cyc_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              tick_q, tick_d;
  logic [NUM_CH-1:0] tick_vec_q, tick_vec_d;

  logic [PTR_W-1:0]  sel_s;
  logic [PTR_W-1:0]  sel_next_s;
  logic [IDX_W-1:0]  idx_s;
  logic              found_s;
  logic              wrap_s;

  // Channel search: first enabled channel at or above the pointer, wrapping around.
  always_comb begin
    sel_s   = ptr_q;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s = {1'b0, ptr_q} + IDX_W'(i);
      if (idx_s >= IDX_W'(NUM_CH)) begin
        idx_s = idx_s - IDX_W'(NUM_CH);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && mask_q[idx_s[PTR_W-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[PTR_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (sel_s == PTR_W'(NUM_CH - 1)) begin
      sel_next_s = '0;
    end else begin
      sel_next_s = sel_s + PTR_W'(1);
    end
  end

  // Next-state, configuration capture and tick generation.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    count_d    = count_q;
    mask_d     = mask_q;
    cyc_d      = cyc_q;
    tcnt_d     = tcnt_q;
    ptr_d      = ptr_q;
    tick_d     = 1'b0;
    tick_vec_d = '0;
    wrap_s     = (cyc_q == (period_q - 20'd1));
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          period_d = (cfg_period <= 20'd1) ? 20'd1 : cfg_period;
          count_d  = cfg_count;
          mask_d   = (cfg_mask == '0) ? '1 : cfg_mask;
        end else begin
          period_d = period_q;
        end
        if (start) begin
          state_d = RUN;
          cyc_d   = '0;
          tcnt_d  = '0;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (wrap_s) begin
          cyc_d      = '0;
          tick_d     = 1'b1;
          tick_vec_d = {{(NUM_CH-1){1'b0}}, 1'b1} << sel_s;
          ptr_d      = sel_next_s;
          tcnt_d     = tcnt_q + 16'd1;
          // A zero count never matches here, so continuous runs just let tcnt wrap.
          if ((count_q != 16'd0) && (tcnt_d == count_q)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          cyc_d = cyc_q + 20'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the default configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      period_q   <= DEF_PERIOD;
      count_q    <= 16'd0;
      mask_q     <= '1;
      cyc_q      <= 20'd0;
      tcnt_q     <= 16'd0;
      ptr_q      <= '0;
      tick_q     <= 1'b0;
      tick_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      count_q    <= count_d;
      mask_q     <= mask_d;
      cyc_q      <= cyc_d;
      tcnt_q     <= tcnt_d;
      ptr_q      <= ptr_d;
      tick_q     <= tick_d;
      tick_vec_q <= tick_vec_d;
    end
  end

  assign tick      = tick_q;
  assign tick_vec  = tick_vec_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, setting the number of tick consumer channels (2..8).
REQ-002 The block SHALL have parameter DEF_PERIOD, default 20'd16, setting the tick period loaded at reset.
REQ-003 The block SHALL have port clk, input, 1, the sole clock; all logic SHALL be rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 The block SHALL have port cfg_valid, input, 1, configuration offer.
REQ-006 The block SHALL have port cfg_ready, output, 1, configuration acceptance.
REQ-007 The block SHALL have port cfg_period, input, 20, cycles per tick.
REQ-008 The block SHALL have port cfg_count, input, 16, ticks per run; 0 means continuous.
REQ-009 The block SHALL have port cfg_mask, input, NUM_CH, channels enabled for tick dispatch.
REQ-010 The block SHALL have port start, input, 1, single-cycle run request.
REQ-011 The block SHALL have port stop, input, 1, single-cycle abort request.
REQ-012 The block SHALL have port tick, output, 1, registered one-cycle tick pulse.
REQ-013 The block SHALL have port tick_vec, output, NUM_CH, one-hot copy of tick on the selected channel.
REQ-014 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse at normal completion.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 cfg_ready SHALL equal 1 in IDLE only; when cfg_valid and cfg_ready are both high, period, count and mask SHALL be latched at that edge.
REQ-018 A latched period of 0 or 1 SHALL be stored as 1 (tick every cycle); a latched mask of 0 SHALL be stored as all-ones.
REQ-019 When start is high in IDLE, the FSM SHALL go to RUN, with cycle counter, tick counter and channel pointer cleared; if cfg_valid is high in the same cycle, the run SHALL use the newly latched configuration.
REQ-020 In RUN, the cycle counter SHALL increment each cycle and wrap to 0 when it equals period-1; tick SHALL go high for exactly one cycle in the cycle after that edge, so the first tick appears exactly period cycles after the start edge, then every period cycles.
REQ-021 Each tick SHALL be dispatched to the lowest enabled channel at or above the channel pointer, wrapping from NUM_CH-1 to 0; the pointer SHALL then advance past that channel. tick_vec SHALL be that channel's one-hot, otherwise 0.
REQ-022 The tick counter SHALL increment per tick; when count is not 0 and the tick that reaches count is issued, the FSM SHALL enter DONE on the same edge.
REQ-023 In DONE, done SHALL be high for one cycle, after which the FSM SHALL return to IDLE; no further tick SHALL be issued.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 When stop is high in RUN or DONE, the FSM SHALL go to IDLE at that edge, any tick due at that edge SHALL be suppressed, and done SHALL NOT pulse.
REQ-026 start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE; stop SHALL take priority over start.
REQ-027 With count = 0, the run SHALL continue until stop; the tick counter SHALL wrap at 16 bits without effect.

Reset
REQ-028 While reset is high, the FSM SHALL be IDLE and tick, tick_vec, done and busy SHALL be 0, and cfg_ready SHALL be 1 from the first cycle after reset.
REQ-029 Reset SHALL restore period=DEF_PERIOD, count=0 and mask=all-ones, and SHALL clear all counters and the channel pointer, including when asserted mid-run.

Verification
REQ-030 Reset, start with defaults -> tick at cycles 16, 32, 48 after the start edge; tick_vec sequence 0001, 0010, 0100, 1000, 0001.
REQ-031 cfg period=3, count=4, mask=0101, with start in the same cycle -> 4 ticks 3 cycles apart on ch0, ch2, ch0, ch2; done on the cycle after the 4th tick edge; then busy=0 and cfg_ready=1.
REQ-032 cfg period=0, count=2 -> ticks on 2 consecutive cycles, then done; mask=0 behaves as 1111.
REQ-033 Continuous run with period=5, then stop on the edge where a tick is due -> no tick, no done, IDLE next cycle; a start during RUN is ignored.
REQ-034 Reset asserted mid-run -> all outputs 0; a following start without cfg runs with period 16 and the channel pointer at ch0.
REQ-035 cfg_valid in RUN -> cfg_ready=0 and configuration unchanged; the same offer held into IDLE is accepted.
